// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    localparam int NREQ_DEF      = 4;
    localparam int DW_DEF        = 8;
    localparam int BURST_LEN_DEF = 4;
    localparam int OWNER_W_DEF   = (NREQ_DEF > 1) ? $clog2(NREQ_DEF) : 1;

    function automatic int owner_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Beat counter must hold the value BURST_LEN itself, not just BURST_LEN-1.
    function automatic int cnt_w(input int burst_len);
        return $clog2(burst_len + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: first set request at or after ptr, searching cyclically.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NREQ requesters.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int  NREQ      = NREQ_DEF,
    parameter int  DW        = DW_DEF,
    parameter int  BURST_LEN = BURST_LEN_DEF,
    localparam int OW        = owner_w(NREQ)
) (
    input  logic              wclk,
    input  logic              wrst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    ack,
    output logic              winc,
    output logic [DW-1:0]      wdata,
    input  logic              wfull,
    output logic              busy,
    output logic [OW-1:0]      owner
);

    localparam int            CW   = cnt_w(BURST_LEN);
    localparam logic [CW-1:0] LAST = CW'(BURST_LEN);

    arb_state_t      state;
    logic [OW-1:0]   rr_ptr;
    logic [OW-1:0]   owner_q;
    logic [CW-1:0]   beat_cnt;

    logic [NREQ-1:0] pick_grant;
    logic [OW-1:0]   pick_idx;
    logic            pick_any;

    function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] i);
        return (int'(i) == NREQ - 1) ? '0 : i + OW'(1);
    endfunction

    rr_pick #(
        .N  (NREQ),
        .IW (OW)
    ) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // The cycle with beat_cnt == LAST is the post-burst bubble: no beat moves.
    always_comb begin
        ack = '0;
        if (!wrst && !wfull) begin
            if (state == ST_IDLE) begin
                ack = pick_grant;
            end else if (beat_cnt != LAST && req[owner_q]) begin
                ack[owner_q] = 1'b1;
            end
        end
    end

    assign winc = |ack;

    always_comb begin
        wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (ack[i]) wdata = req_data[i*DW +: DW];
        end
    end

    assign busy  = (state == ST_BURST) && !wrst;
    assign owner = wrst ? '0 : owner_q;

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            owner_q  <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!wfull && pick_any) begin
                        owner_q  <= pick_idx;
                        beat_cnt <= CW'(1);
                        if (BURST_LEN > 1) begin
                            state <= ST_BURST;
                        end else begin
                            rr_ptr <= next_idx(pick_idx);
                        end
                    end
                end
                ST_BURST: begin
                    if (beat_cnt == LAST) begin
                        state  <= ST_IDLE;
                        rr_ptr <= next_idx(owner_q);
                    end else if (wfull) begin
                        state <= ST_BURST;
                    end else if (req[owner_q]) begin
                        beat_cnt <= beat_cnt + CW'(1);
                    end else begin
                        state  <= ST_IDLE;
                        rr_ptr <= next_idx(owner_q);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with NREQ=4, DW=8, BURST_LEN=4.
module tb_fifo_wr_arbiter;

    logic        wclk;
    logic        wrst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        winc;
    logic [7:0]  wdata;
    logic        wfull;
    logic        busy;
    logic [1:0]  owner;

    int checks;
    int fails;

    fifo_wr_arbiter #(
        .NREQ      (4),
        .DW        (8),
        .BURST_LEN (4)
    ) dut (
        .wclk     (wclk),
        .wrst     (wrst),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .winc     (winc),
        .wdata    (wdata),
        .wfull    (wfull),
        .busy     (busy),
        .owner    (owner)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    function automatic logic [7:0] exp_data(input logic [3:0] a);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (a[i]) r = req_data[i*8 +: 8];
        end
        return r;
    endfunction

    task automatic adv;
        @(posedge wclk);
        #1;
    endtask

    task automatic settle;
        @(negedge wclk);
        checks++;
        if (winc && wfull) begin
            fails++;
            $display("FAIL inv_full: winc=%b while wfull=%b", winc, wfull);
        end
        checks++;
        if (!$onehot0(ack)) begin
            fails++;
            $display("FAIL inv_onehot: ack=%b is not one-hot-or-zero", ack);
        end
        checks++;
        if (winc !== (|ack)) begin
            fails++;
            $display("FAIL inv_winc: winc=%b want %b", winc, |ack);
        end
        checks++;
        if (wdata !== exp_data(ack)) begin
            fails++;
            $display("FAIL inv_wdata: wdata=%h want %h", wdata, exp_data(ack));
        end
    endtask

    task automatic test_reset;
        wrst = 1'b1;
        req  = 4'hF;
        wfull = 1'b0;
        adv();
        adv();
        settle();
        checks++;
        if (ack !== 4'b0000 || winc !== 1'b0 || wdata !== 8'h00) begin
            fails++;
            $display("FAIL reset_out: ack=%b winc=%b wdata=%h want 0/0/00", ack, winc, wdata);
        end
        checks++;
        if (busy !== 1'b0 || owner !== 2'd0) begin
            fails++;
            $display("FAIL reset_state: busy=%b owner=%0d want 0/0", busy, owner);
        end
        checks++;
        if (dut.rr_ptr !== 2'd0 || dut.beat_cnt !== 3'd0) begin
            fails++;
            $display("FAIL reset_regs: rr_ptr=%0d beat_cnt=%0d want 0/0", dut.rr_ptr, dut.beat_cnt);
        end
        adv();
        wrst = 1'b0;
        req  = 4'b0000;
    endtask

    task automatic test_basic;
        int ack_t[11];
        int busy_t[11];
        int own_t[11];
        ack_t  = '{2, 2, 2, 2, 0, 8, 8, 8, 8, 0, 0};
        busy_t = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        own_t  = '{0, 1, 1, 1, 1, 1, 3, 3, 3, 3, 3};
        for (int c = 0; c < 11; c++) begin
            req   = (c < 10) ? 4'b1010 : 4'b0000;
            wfull = 1'b0;
            settle();
            checks++;
            if (ack !== 4'(ack_t[c])) begin
                fails++;
                $display("FAIL basic_ack cycle %0d: got %b want %b", c, ack, 4'(ack_t[c]));
            end
            checks++;
            if (busy !== 1'(busy_t[c])) begin
                fails++;
                $display("FAIL basic_busy cycle %0d: got %b want %0d", c, busy, busy_t[c]);
            end
            checks++;
            if (owner !== 2'(own_t[c])) begin
                fails++;
                $display("FAIL basic_owner cycle %0d: got %0d want %0d", c, owner, own_t[c]);
            end
            checks++;
            if (wdata !== exp_data(4'(ack_t[c]))) begin
                fails++;
                $display("FAIL basic_wdata cycle %0d: got %h want %h", c, wdata, exp_data(4'(ack_t[c])));
            end
            adv();
        end
        checks++;
        if (dut.rr_ptr !== 2'd0) begin
            fails++;
            $display("FAIL basic_rr_ptr: got %0d want 0", dut.rr_ptr);
        end
    endtask

    task automatic test_wfull_stall;
        int req_t[11];
        int full_t[11];
        int ack_t[11];
        int busy_t[11];
        int own_t[11];
        req_t  = '{4, 15, 15, 15, 15, 15, 15, 15, 15, 0, 0};
        full_t = '{0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        ack_t  = '{4, 4, 0, 0, 0, 0, 0, 4, 4, 0, 0};
        busy_t = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        own_t  = '{3, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2};
        for (int c = 0; c < 11; c++) begin
            req   = 4'(req_t[c]);
            wfull = 1'(full_t[c]);
            settle();
            checks++;
            if (ack !== 4'(ack_t[c])) begin
                fails++;
                $display("FAIL stall_ack cycle %0d: got %b want %b", c, ack, 4'(ack_t[c]));
            end
            checks++;
            if (busy !== 1'(busy_t[c])) begin
                fails++;
                $display("FAIL stall_busy cycle %0d: got %b want %0d", c, busy, busy_t[c]);
            end
            checks++;
            if (owner !== 2'(own_t[c])) begin
                fails++;
                $display("FAIL stall_owner cycle %0d: got %0d want %0d", c, owner, own_t[c]);
            end
            checks++;
            if (wdata !== exp_data(4'(ack_t[c]))) begin
                fails++;
                $display("FAIL stall_wdata cycle %0d: got %h want %h", c, wdata, exp_data(4'(ack_t[c])));
            end
            adv();
        end
        checks++;
        if (dut.rr_ptr !== 2'd3) begin
            fails++;
            $display("FAIL stall_rr_ptr: got %0d want 3", dut.rr_ptr);
        end
    endtask

    task automatic test_idle_full;
        for (int c = 0; c < 2; c++) begin
            req   = 4'b0001;
            wfull = 1'b1;
            settle();
            checks++;
            if (ack !== 4'b0000 || busy !== 1'b0 || owner !== 2'd2) begin
                fails++;
                $display("FAIL idle_full cycle %0d: ack=%b busy=%b owner=%0d want 0000/0/2", c, ack, busy, owner);
            end
            adv();
        end
        checks++;
        if (dut.rr_ptr !== 2'd3) begin
            fails++;
            $display("FAIL idle_full_rr_ptr: got %0d want 3", dut.rr_ptr);
        end
    endtask

    task automatic test_release;
        int req_t[5];
        int ack_t[5];
        int busy_t[5];
        int own_t[5];
        req_t  = '{1, 8, 9, 0, 0};
        ack_t  = '{1, 0, 8, 0, 0};
        busy_t = '{0, 1, 0, 1, 0};
        own_t  = '{2, 0, 0, 3, 3};
        for (int c = 0; c < 5; c++) begin
            req   = 4'(req_t[c]);
            wfull = 1'b0;
            settle();
            checks++;
            if (ack !== 4'(ack_t[c])) begin
                fails++;
                $display("FAIL release_ack cycle %0d: got %b want %b", c, ack, 4'(ack_t[c]));
            end
            checks++;
            if (busy !== 1'(busy_t[c])) begin
                fails++;
                $display("FAIL release_busy cycle %0d: got %b want %0d", c, busy, busy_t[c]);
            end
            checks++;
            if (owner !== 2'(own_t[c])) begin
                fails++;
                $display("FAIL release_owner cycle %0d: got %0d want %0d", c, owner, own_t[c]);
            end
            adv();
        end
        checks++;
        if (dut.rr_ptr !== 2'd0) begin
            fails++;
            $display("FAIL release_rr_ptr: got %0d want 0", dut.rr_ptr);
        end
    endtask

    task automatic test_fairness;
        int cnt[4];
        int order[$];
        int idx;
        cnt = '{0, 0, 0, 0};
        for (int c = 0; c < 60; c++) begin
            req   = 4'hF;
            wfull = 1'b0;
            settle();
            if (ack != 4'b0000) begin
                idx = 0;
                for (int i = 0; i < 4; i++) begin
                    if (ack[i]) idx = i;
                end
                cnt[idx]++;
                if (!busy) order.push_back(idx);
            end
            adv();
        end
        checks++;
        if (order.size() != 12) begin
            fails++;
            $display("FAIL fair_grants: got %0d grants want 12", order.size());
        end
        for (int k = 0; k < order.size(); k++) begin
            checks++;
            if (order[k] != k % 4) begin
                fails++;
                $display("FAIL fair_order grant %0d: got %0d want %0d", k, order[k], k % 4);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cnt[i] != 12) begin
                fails++;
                $display("FAIL fair_beats req %0d: got %0d want 12", i, cnt[i]);
            end
        end
        req = 4'b0000;
        settle();
        checks++;
        if (ack !== 4'b0000 || busy !== 1'b0 || dut.rr_ptr !== 2'd0) begin
            fails++;
            $display("FAIL fair_end: ack=%b busy=%b rr_ptr=%0d want 0000/0/0", ack, busy, dut.rr_ptr);
        end
        adv();
    endtask

    task automatic test_reset_midburst;
        int rst_t[9];
        int ack_t[9];
        int busy_t[9];
        int own_t[9];
        rst_t  = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
        ack_t  = '{2, 2, 0, 2, 2, 2, 2, 0, 0};
        busy_t = '{0, 1, 0, 0, 1, 1, 1, 1, 0};
        own_t  = '{3, 1, 0, 0, 1, 1, 1, 1, 1};
        for (int c = 0; c < 9; c++) begin
            wrst  = 1'(rst_t[c]);
            req   = (c < 8) ? 4'b0010 : 4'b0000;
            wfull = 1'b0;
            settle();
            checks++;
            if (ack !== 4'(ack_t[c])) begin
                fails++;
                $display("FAIL rstmid_ack cycle %0d: got %b want %b", c, ack, 4'(ack_t[c]));
            end
            checks++;
            if (busy !== 1'(busy_t[c]) || owner !== 2'(own_t[c])) begin
                fails++;
                $display("FAIL rstmid_state cycle %0d: busy=%b owner=%0d want %0d/%0d", c, busy, owner, busy_t[c], own_t[c]);
            end
            checks++;
            if (wdata !== exp_data(4'(ack_t[c]))) begin
                fails++;
                $display("FAIL rstmid_wdata cycle %0d: got %h want %h", c, wdata, exp_data(4'(ack_t[c])));
            end
            if (c == 4) begin
                checks++;
                if (dut.beat_cnt !== 3'd1) begin
                    fails++;
                    $display("FAIL rstmid_beat_cnt: got %0d want 1", dut.beat_cnt);
                end
            end
            adv();
        end
    endtask

    initial begin
        checks   = 0;
        fails    = 0;
        wrst     = 1'b1;
        req      = 4'b0000;
        wfull    = 1'b0;
        req_data = 32'hC3B2A190;
        test_reset();
        test_basic();
        test_wfull_stall();
        test_idle_full();
        test_release();
        test_fairness();
        test_reset_midburst();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
